// File: rtl/rv32v_elem_sequencer.sv
// Element sequencer for RV32 vector ops: turns (sew, lmul, vl, vstart)
// into NUM_LANES-wide beats of element indices, lane enables and offsets.
//
// Ports:
//   CLK, RST          clock (rising edge), async active-high reset
//   start             begin a sequence (sampled in IDLE only)
//   flush             abort to IDLE, no done pulse
//   stall             hold the current beat
//   sew, lmul         element width / group multiplier encodings
//   vl, vstart        requested vector length, first element index
//   busy              sequencer is not IDLE
//   valid             beat present (RUN only)
//   elem_idx          lane i index = base+i in slice i
//   lane_en           lane i active (index below effective vl)
//   reg_off/byte_off  register in group / byte in register of base
//   last              final beat of the sequence
//   done              one-cycle completion pulse
//   illegal           one-cycle bad-configuration pulse
module rv32v_elem_sequencer #(
    parameter int VLEN      = 128,
    parameter int NUM_LANES = 2
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               start,
    input  logic                               flush,
    input  logic                               stall,
    input  logic [2:0]                         sew,
    input  logic [2:0]                         lmul,
    input  logic [$clog2(VLEN):0]              vl,
    input  logic [$clog2(VLEN):0]              vstart,
    output logic                               busy,
    output logic                               valid,
    output logic [NUM_LANES*($clog2(VLEN)+1)-1:0] elem_idx,
    output logic [NUM_LANES-1:0]               lane_en,
    output logic [2:0]                         reg_off,
    output logic [$clog2(VLEN/8)-1:0]          byte_off,
    output logic                               last,
    output logic                               done,
    output logic                               illegal
);

    localparam int VLENB = VLEN / 8;
    localparam int VLW   = $clog2(VLEN) + 1;
    localparam int BOW   = $clog2(VLENB);
    // One extra bit so base+NUM_LANES can never wrap.
    localparam int IW    = VLW + 1;
    localparam int AW    = IW + 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q,   state_d;
    logic [1:0]    sew_q,     sew_d;
    logic [IW-1:0] eff_vl_q,  eff_vl_d;
    logic [IW-1:0] base_q,    base_d;
    logic          illegal_q, illegal_d;

    logic [IW-1:0] sew_elems;
    logic [IW-1:0] vlmax;
    logic [IW-1:0] vl_ext;
    logic [IW-1:0] vstart_ext;
    logic [IW-1:0] eff_vl;
    logic          cfg_ok;
    logic          run;
    logic          last_int;
    logic [IW-1:0] lane_sum;
    logic [AW-1:0] addr;
    logic          addr_unused;

    // VLMAX = (VLEN >> (sew+3)) scaled by LMUL.
    always_comb begin
        sew_elems = '0;
        case (sew)
            3'd0:    sew_elems = IW'(VLEN / 8);
            3'd1:    sew_elems = IW'(VLEN / 16);
            3'd2:    sew_elems = IW'(VLEN / 32);
            default: sew_elems = IW'(VLEN / 64);
        endcase
        vlmax = '0;
        case (lmul)
            3'd0:    vlmax = sew_elems;
            3'd1:    vlmax = sew_elems << 1;
            3'd2:    vlmax = sew_elems << 2;
            3'd3:    vlmax = sew_elems << 3;
            3'd5:    vlmax = sew_elems >> 3;
            3'd6:    vlmax = sew_elems >> 2;
            3'd7:    vlmax = sew_elems >> 1;
            default: vlmax = '0;
        endcase
    end

    assign vl_ext     = IW'(vl);
    assign vstart_ext = IW'(vstart);
    assign eff_vl     = (vl_ext < vlmax) ? vl_ext : vlmax;
    assign cfg_ok     = (sew <= 3'd2) && (lmul != 3'd4)
                        && (vlmax != '0);

    assign run      = (state_q == S_RUN);
    assign last_int = (base_q + IW'(NUM_LANES)) >= eff_vl_q;

    always_comb begin
        state_d   = state_q;
        sew_d     = sew_q;
        eff_vl_d  = eff_vl_q;
        base_d    = base_q;
        illegal_d = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (!cfg_ok) begin
                            illegal_d = 1'b1;
                        end else begin
                            sew_d    = sew[1:0];
                            eff_vl_d = eff_vl;
                            base_d   = vstart_ext;
                            state_d  = (vstart_ext >= eff_vl)
                                       ? S_DONE : S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (last_int) begin
                            state_d = S_DONE;
                        end else begin
                            base_d = base_q + IW'(NUM_LANES);
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            sew_q     <= '0;
            eff_vl_q  <= '0;
            base_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sew_q     <= sew_d;
            eff_vl_q  <= eff_vl_d;
            base_q    <= base_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        elem_idx = '0;
        lane_en  = '0;
        lane_sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_sum = base_q + IW'(i);
            if (run) begin
                elem_idx[i*VLW +: VLW] = lane_sum[VLW-1:0];
                lane_en[i] = (lane_sum < eff_vl_q);
            end
        end
    end

    // Byte address of base within the register group.
    assign addr        = AW'(base_q) << sew_q;
    assign addr_unused = ^addr[AW-1:BOW+3];

    assign busy     = (state_q != S_IDLE);
    assign valid    = run;
    assign last     = run && last_int;
    assign reg_off  = run ? addr[BOW+2:BOW] : 3'd0;
    assign byte_off = run ? addr[BOW-1:0] : '0;
    assign done     = (state_q == S_DONE);
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_rv32v_elem_sequencer.sv
// Directed bench for rv32v_elem_sequencer (VLEN=128, NUM_LANES=2).
// Each task drives one scenario and compares outputs inline.
module tb_rv32v_elem_sequencer;

    logic        CLK;
    logic        RST;
    logic        start;
    logic        flush;
    logic        stall;
    logic [2:0]  sew;
    logic [2:0]  lmul;
    logic [7:0]  vl;
    logic [7:0]  vstart;
    logic        busy;
    logic        valid;
    logic [15:0] elem_idx;
    logic [1:0]  lane_en;
    logic [2:0]  reg_off;
    logic [3:0]  byte_off;
    logic        last;
    logic        done;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] ctl;
    assign ctl = {busy, valid, last, done, illegal,
                  lane_en, reg_off, byte_off};

    localparam logic [13:0] IDLE_V = 14'h0000;
    localparam logic [13:0] DONE_V = {4'b1001, 10'd0};
    localparam logic [13:0] ILL_V  = {4'b0000, 1'b1, 9'd0};

    rv32v_elem_sequencer #(.VLEN(128), .NUM_LANES(2)) dut (
        .CLK(CLK), .RST(RST), .start(start), .flush(flush),
        .stall(stall), .sew(sew), .lmul(lmul), .vl(vl),
        .vstart(vstart), .busy(busy), .valid(valid),
        .elem_idx(elem_idx), .lane_en(lane_en),
        .reg_off(reg_off), .byte_off(byte_off), .last(last),
        .done(done), .illegal(illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [13:0] beat(input logic l,
        input logic [1:0] en, input logic [2:0] r,
        input logic [3:0] b);
        return {1'b1, 1'b1, l, 1'b0, 1'b0, en, r, b};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic go(input logic [2:0] s, input logic [2:0] m,
                      input logic [7:0] v, input logic [7:0] vs);
        sew = s; lmul = m; vl = v; vstart = vs;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({ctl, elem_idx} !== {IDLE_V, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_hold ctl=%h idx=%h want %h/0000",
                     ctl, elem_idx, IDLE_V);
        end
        tick();
        RST = 1'b0;
        tick();
        n_checks++;
        if (ctl !== IDLE_V) begin
            n_fail++;
            $display("FAIL reset_release ctl=%h want %h", ctl, IDLE_V);
        end
    endtask

    task automatic test_basic();
        go(3'd2, 3'd0, 8'd4, 8'd0);
        n_checks++;
        if ({ctl, elem_idx} !== {beat(0, 2'b11, 0, 0), 16'h0100}) begin
            n_fail++;
            $display("FAIL basic_b0 ctl=%h idx=%h", ctl, elem_idx);
        end
        tick();
        n_checks++;
        if ({ctl, elem_idx} !== {beat(1, 2'b11, 0, 8), 16'h0302}) begin
            n_fail++;
            $display("FAIL basic_b1 ctl=%h idx=%h", ctl, elem_idx);
        end
        tick();
        n_checks++;
        if ({ctl, elem_idx} !== {DONE_V, 16'h0}) begin
            n_fail++;
            $display("FAIL basic_done ctl=%h idx=%h want %h",
                     ctl, elem_idx, DONE_V);
        end
        tick();
        n_checks++;
        if (ctl !== IDLE_V) begin
            n_fail++;
            $display("FAIL basic_idle ctl=%h want %h", ctl, IDLE_V);
        end
    endtask

    task automatic test_lmul2();
        go(3'd2, 3'd1, 8'd5, 8'd0);
        n_checks++;
        if ({ctl, elem_idx} !== {beat(0, 2'b11, 0, 0), 16'h0100}) begin
            n_fail++;
            $display("FAIL lmul2_b0 ctl=%h idx=%h", ctl, elem_idx);
        end
        // A start while busy with a different config must be ignored.
        sew = 3'd0; vl = 8'd100; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({ctl, elem_idx} !== {beat(0, 2'b11, 0, 8), 16'h0302}) begin
            n_fail++;
            $display("FAIL lmul2_b1 ctl=%h idx=%h", ctl, elem_idx);
        end
        tick();
        n_checks++;
        if ({ctl, elem_idx} !== {beat(1, 2'b01, 1, 0), 16'h0504}) begin
            n_fail++;
            $display("FAIL lmul2_b2 ctl=%h idx=%h", ctl, elem_idx);
        end
        tick();
        n_checks++;
        if (ctl !== DONE_V) begin
            n_fail++;
            $display("FAIL lmul2_done ctl=%h want %h", ctl, DONE_V);
        end
        tick();
    endtask

    task automatic test_sew8();
        go(3'd0, 3'd0, 8'd100, 8'd0);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if ({ctl, elem_idx} !== {beat(k == 7, 2'b11, 3'd0,
                 4'(2 * k)), 8'(2 * k + 1), 8'(2 * k)}) begin
                n_fail++;
                $display("FAIL sew8_b%0d ctl=%h idx=%h", k, ctl,
                         elem_idx);
            end
            tick();
        end
        n_checks++;
        if (ctl !== DONE_V) begin
            n_fail++;
            $display("FAIL sew8_done ctl=%h want %h", ctl, DONE_V);
        end
        tick();
    endtask

    task automatic test_stall();
        go(3'd2, 3'd0, 8'd4, 8'd0);
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({ctl, elem_idx} !== {beat(0, 2'b11, 0, 0),
                                     16'h0100}) begin
                n_fail++;
                $display("FAIL stall_hold%0d ctl=%h idx=%h", k, ctl,
                         elem_idx);
            end
            if (k == 3) stall = 1'b0;
            else tick();
        end
        tick();
        n_checks++;
        if ({ctl, elem_idx} !== {beat(1, 2'b11, 0, 8), 16'h0302}) begin
            n_fail++;
            $display("FAIL stall_b1 ctl=%h idx=%h", ctl, elem_idx);
        end
        tick();
        n_checks++;
        if (ctl !== DONE_V) begin
            n_fail++;
            $display("FAIL stall_done ctl=%h want %h", ctl, DONE_V);
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [5:0] cfg [3];
        cfg[0] = {3'd3, 3'd0};
        cfg[1] = {3'd2, 3'd4};
        cfg[2] = {3'd2, 3'd5};
        for (int k = 0; k < 3; k++) begin
            go(cfg[k][5:3], cfg[k][2:0], 8'd4, 8'd0);
            n_checks++;
            if (ctl !== ILL_V) begin
                n_fail++;
                $display("FAIL illegal%0d_pulse ctl=%h want %h", k,
                         ctl, ILL_V);
            end
            tick();
            n_checks++;
            if (ctl !== IDLE_V) begin
                n_fail++;
                $display("FAIL illegal%0d_clear ctl=%h want %h", k,
                         ctl, IDLE_V);
            end
        end
    endtask

    task automatic test_skip();
        go(3'd2, 3'd0, 8'd4, 8'd4);
        n_checks++;
        if (ctl !== DONE_V) begin
            n_fail++;
            $display("FAIL skip_done ctl=%h want %h", ctl, DONE_V);
        end
        tick();
        n_checks++;
        if (ctl !== IDLE_V) begin
            n_fail++;
            $display("FAIL skip_idle ctl=%h want %h", ctl, IDLE_V);
        end
    endtask

    task automatic test_flush();
        go(3'd2, 3'd0, 8'd4, 8'd0);
        tick();
        n_checks++;
        if (ctl !== beat(1, 2'b11, 0, 8)) begin
            n_fail++;
            $display("FAIL flush_b1 ctl=%h", ctl);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (ctl !== IDLE_V) begin
            n_fail++;
            $display("FAIL flush_idle ctl=%h want %h", ctl, IDLE_V);
        end
        tick();
        n_checks++;
        if (ctl !== IDLE_V) begin
            n_fail++;
            $display("FAIL flush_nodone ctl=%h want %h", ctl, IDLE_V);
        end
    endtask

    task automatic test_rst_mid();
        go(3'd2, 3'd0, 8'd4, 8'd0);
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({ctl, elem_idx} !== {IDLE_V, 16'h0}) begin
            n_fail++;
            $display("FAIL rst_mid ctl=%h idx=%h want 0", ctl,
                     elem_idx);
        end
        RST = 1'b0;
        go(3'd2, 3'd0, 8'd4, 8'd0);
        n_checks++;
        if ({ctl, elem_idx} !== {beat(0, 2'b11, 0, 0), 16'h0100}) begin
            n_fail++;
            $display("FAIL rst_restart ctl=%h idx=%h", ctl, elem_idx);
        end
        tick();
        tick();
        n_checks++;
        if (ctl !== DONE_V) begin
            n_fail++;
            $display("FAIL rst_restart_done ctl=%h want %h", ctl,
                     DONE_V);
        end
        tick();
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; flush = 1'b0; stall = 1'b0;
        sew = 3'd0; lmul = 3'd0; vl = 8'd0; vstart = 8'd0;
        test_reset();
        test_basic();
        test_lmul2();
        test_sew8();
        test_stall();
        test_illegal();
        test_skip();
        test_flush();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
